// File: rtl/divider_32.sv
// Sequential radix-2 restoring divider: one quotient bit per cycle, fixed 33-cycle latency.
// Handles signed/unsigned operands, divide-by-zero and the signed MIN/-1 overflow case.
module divider_32 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             is_signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] AllOnes = {WIDTH{1'b1}};

    typedef enum logic [1:0] {StIdle, StIter, StFix} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [WIDTH:0]    rem_q, rem_d;
    logic [WIDTH-1:0]  dvd_q, dvd_d;
    logic [WIDTH-1:0]  dsr_mag_q, dsr_mag_d;
    logic [WIDTH-1:0]  dvd_raw_q, dvd_raw_d;
    logic              q_neg_q, q_neg_d;
    logic              r_neg_q, r_neg_d;
    logic              ovf_q, ovf_d;
    logic [WIDTH-1:0]  quo_q, quo_d;
    logic [WIDTH-1:0]  rmd_q, rmd_d;
    logic              dz_q, dz_d;
    logic              done_q, done_d;

    logic              dividend_neg;
    logic              divisor_neg;
    logic [WIDTH-1:0]  dividend_mag;
    logic [WIDTH-1:0]  divisor_mag;
    logic [WIDTH:0]    rem_shift;
    logic [WIDTH:0]    trial;
    logic [WIDTH-1:0]  q_mag;
    logic [WIDTH-1:0]  r_mag;

    always_comb begin
        dividend_neg = is_signed_i & dividend_i[WIDTH-1];
        divisor_neg  = is_signed_i & divisor_i[WIDTH-1];
        dividend_mag = dividend_neg ? (~dividend_i + 1'b1) : dividend_i;
        divisor_mag  = divisor_neg ? (~divisor_i + 1'b1) : divisor_i;
    end

    // dvd_q doubles as the quotient accumulator: dividend bits shift out the top
    // while quotient bits shift in at the bottom.
    always_comb begin
        rem_shift = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
        trial     = rem_shift - {1'b0, dsr_mag_q};
        q_mag     = dvd_q;
        r_mag     = rem_q[WIDTH-1:0];
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dsr_mag_d = dsr_mag_q;
        dvd_raw_d = dvd_raw_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        ovf_d     = ovf_q;
        quo_d     = quo_q;
        rmd_d     = rmd_q;
        dz_d      = dz_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    dvd_d     = dividend_mag;
                    dsr_mag_d = divisor_mag;
                    dvd_raw_d = dividend_i;
                    q_neg_d   = dividend_neg ^ divisor_neg;
                    r_neg_d   = dividend_neg;
                    ovf_d     = is_signed_i && (dividend_i == MinNeg) && (divisor_i == AllOnes);
                    rem_d     = '0;
                    count_d   = '0;
                    state_d   = StIter;
                end
            end
            StIter: begin
                if (trial[WIDTH]) begin
                    rem_d = rem_shift;
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                end else begin
                    rem_d = trial;
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
                end
                count_d = count_q + 1'b1;
                if (count_q == LastCnt) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                done_d  = 1'b1;
                state_d = StIdle;
                if (dsr_mag_q == '0) begin
                    quo_d = AllOnes;
                    rmd_d = dvd_raw_q;
                    dz_d  = 1'b1;
                end else if (ovf_q) begin
                    quo_d = MinNeg;
                    rmd_d = '0;
                    dz_d  = 1'b0;
                end else begin
                    quo_d = q_neg_q ? (~q_mag + 1'b1) : q_mag;
                    rmd_d = r_neg_q ? (~r_mag + 1'b1) : r_mag;
                    dz_d  = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            count_q   <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dsr_mag_q <= '0;
            dvd_raw_q <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            ovf_q     <= 1'b0;
            quo_q     <= '0;
            rmd_q     <= '0;
            dz_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            dsr_mag_q <= dsr_mag_d;
            dvd_raw_q <= dvd_raw_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            ovf_q     <= ovf_d;
            quo_q     <= quo_d;
            rmd_q     <= rmd_d;
            dz_q      <= dz_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        busy_o        = (state_q != StIdle);
        done_o        = done_q;
        quotient_o    = quo_q;
        remainder_o   = rmd_q;
        div_by_zero_o = dz_q;
    end

endmodule
